// File: rtl/datapath.sv
// Multi-cycle processor datapath: general registers R0-R6, PC, A, G, IR, ADDR, DOUT,
// a 4-way shared bus, the ALU, and the registered memory write enable.
module datapath #(
  parameter int DATA_W = 16,
  parameter int IR_W   = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] DIN,
  input  logic              IR_in,
  input  logic              A_in,
  input  logic              G_in,
  input  logic              ADDR_in,
  input  logic              DOUT_in,
  input  logic              W_D,
  input  logic              incr_PC,
  input  logic              PC_in,
  input  logic [1:0]        mux_control,
  input  logic [2:0]        register_out,
  input  logic [6:0]        register_in,
  input  logic [3:0]        ULA_control,
  output logic [IR_W-1:0]   IR,
  output logic              G_or,
  output logic [DATA_W-1:0] ADDR,
  output logic [DATA_W-1:0] DOUT,
  output logic              W,
  output logic [DATA_W-1:0] PC
);

  logic [DATA_W-1:0] r_regs [0:6];
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_g;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dout;
  logic [IR_W-1:0]   r_ir;
  logic              r_w;

  logic [DATA_W-1:0] w_regBus;
  logic [DATA_W-1:0] w_bus;
  logic [DATA_W-1:0] w_alu;

  // Register-file read port; register_out=7 has no register behind it and reads as zero.
  always_comb begin
    w_regBus = '0;
    for (int i = 0; i < 7; i++) begin
      if (register_out == i[2:0]) w_regBus = r_regs[i];
    end
  end

  always_comb begin
    w_bus = '0;
    case (mux_control)
      2'b00:   w_bus = DIN;
      2'b01:   w_bus = w_regBus;
      2'b10:   w_bus = r_pc;
      default: w_bus = r_g;
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (ULA_control)
      4'b0101: w_alu = r_a + w_bus;
      4'b0110: w_alu = r_a - w_bus;
      4'b0111: w_alu = r_a | w_bus;
      4'b1000: w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(w_bus))};
      4'b1001: w_alu = r_a << w_bus[3:0];
      4'b1010: w_alu = r_a >> w_bus[3:0];
      default: w_alu = '0;
    endcase
  end

  // Every register samples the bus as it stood before this edge, so reads and writes
  // of the same register in one cycle see the old value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 7; i++) r_regs[i] <= '0;
      r_pc   <= '0;
      r_a    <= '0;
      r_g    <= '0;
      r_addr <= '0;
      r_dout <= '0;
      r_ir   <= '0;
      r_w    <= 1'b0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (register_in[i]) r_regs[i] <= w_bus;
      end
      if (PC_in)        r_pc <= w_bus;
      else if (incr_PC) r_pc <= r_pc + DATA_W'(1);
      if (A_in)    r_a    <= w_bus;
      if (G_in)    r_g    <= w_alu;
      if (ADDR_in) r_addr <= w_bus;
      if (DOUT_in) r_dout <= w_bus;
      if (IR_in)   r_ir   <= w_bus[IR_W-1:0];
      r_w <= W_D;
    end
  end

  assign IR   = r_ir;
  assign G_or = |r_g;
  assign ADDR = r_addr;
  assign DOUT = r_dout;
  assign W    = r_w;
  assign PC   = r_pc;

endmodule
